// File: rtl/clk_divider_prog.sv
// clk_divider_prog: programmable clock divider with toggle, pulse and hold-low modes.
// Configuration is staged in a shadow register and applied only at a period boundary.
module clk_divider_prog #(
  parameter int CNT_WIDTH   = 16,
  parameter int DEFAULT_DIV = 50
) (
  input  logic                 clk_in,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [CNT_WIDTH-1:0] div_value,
  input  logic [1:0]           mode_sel,
  input  logic                 div_load,
  output logic                 clk_out,
  output logic                 tick,
  output logic                 div_pending,
  output logic                 div_err
);
  localparam logic [1:0] M_TOGGLE = 2'b00;
  localparam logic [1:0] M_PULSE  = 2'b01;
  localparam logic [1:0] M_HOLD   = 2'b10;
  localparam logic [CNT_WIDTH-1:0] DEF_DIV = CNT_WIDTH'(DEFAULT_DIV);
  localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);
  logic [CNT_WIDTH-1:0] counter, div_active, div_shadow, cnt_next;
  logic [1:0]           mode_active, mode_shadow, mode_in;
  logic                 terminal, apply, mode_change, run_out, clk_next;
  logic                 load_ok, load_err;
  always_comb begin
    terminal    = enable && (counter >= div_active - ONE);
    apply       = div_pending && (terminal || !enable);
    mode_change = mode_shadow != mode_active;
    // the old mode still decides the edge that closes the current period
    run_out     = (mode_active == M_TOGGLE) ? (clk_out ^ terminal) :
                  (mode_active == M_PULSE)  ? terminal : 1'b0;
    clk_next    = !enable ? (apply ? 1'b0 : clk_out) :
                  (apply && mode_change) ? 1'b0 : run_out;
    cnt_next    = (terminal || apply) ? '0 : enable ? counter + ONE : counter;
    load_ok     = div_load && (div_value != '0);
    load_err    = div_load && (div_value == '0);
    mode_in     = (mode_sel == 2'b11) ? M_TOGGLE : mode_sel;
  end
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      counter     <= '0;
      clk_out     <= 1'b0;
      tick        <= 1'b0;
      div_err     <= 1'b0;
      div_pending <= 1'b0;
      div_active  <= DEF_DIV;
      div_shadow  <= DEF_DIV;
      mode_active <= M_TOGGLE;
      mode_shadow <= M_TOGGLE;
    end else begin
      counter <= cnt_next;
      clk_out <= clk_next;
      tick    <= clk_next && !clk_out;
      div_err <= load_err;
      if (apply) begin
        div_active  <= div_shadow;
        mode_active <= mode_shadow;
      end
      // a load in the apply cycle re-arms pending with the new values
      if (load_ok) begin
        div_shadow  <= div_value;
        mode_shadow <= mode_in;
      end
      div_pending <= load_ok ? 1'b1 : apply ? 1'b0 : div_pending;
    end
  end
  logic unused_hold;
  assign unused_hold = (M_HOLD == 2'b10);
endmodule

// File: tb/tb_clk_divider_prog.sv
// tb_clk_divider_prog: randomized scoreboard bench for clk_divider_prog.
module tb_clk_divider_prog;
  localparam int W = 16;
  logic clk_in = 1'b0;
  logic reset_n = 1'b0, enable = 1'b0, div_load = 1'b0;
  logic [W-1:0] div_value = '0;
  logic [1:0] mode_sel = '0;
  logic clk_out, tick, div_pending, div_err;
  int checks = 0, errors = 0;
  logic [3:0] exp_q[$];
  int m_cnt, m_n, m_ns, m_mode, m_ms;
  bit m_out, m_tick, m_pend, m_err;

  always #5 clk_in = ~clk_in;

  clk_divider_prog #(.CNT_WIDTH(W), .DEFAULT_DIV(50)) dut (
    .clk_in(clk_in), .reset_n(reset_n), .enable(enable), .div_value(div_value),
    .mode_sel(mode_sel), .div_load(div_load), .clk_out(clk_out), .tick(tick),
    .div_pending(div_pending), .div_err(div_err)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference: cycles since period start, divisor and mode as plain integers.
  task automatic model_step();
    bit term, app, nxt;
    if (!reset_n) begin
      m_cnt = 0; m_n = 50; m_ns = 50; m_mode = 0; m_ms = 0;
      m_out = 0; m_tick = 0; m_pend = 0; m_err = 0;
    end else begin
      term = enable && (m_cnt + 1 >= m_n);
      app  = m_pend && (term || !enable);
      if (!enable) nxt = app ? 1'b0 : m_out;
      else if (app && m_ms != m_mode) nxt = 1'b0;
      else if (m_mode == 0) nxt = term ? !m_out : m_out;
      else if (m_mode == 1) nxt = term;
      else nxt = 1'b0;
      m_tick = nxt && !m_out;
      m_out  = nxt;
      m_cnt  = (term || app) ? 0 : (enable ? m_cnt + 1 : m_cnt);
      if (app) begin m_n = m_ns; m_mode = m_ms; m_pend = 0; end
      m_err = div_load && div_value == 0;
      if (div_load && div_value != 0) begin
        m_ns = int'(div_value); m_ms = (mode_sel == 2'b11) ? 0 : int'(mode_sel); m_pend = 1;
      end
    end
    exp_q.push_back({m_out, m_tick, m_pend, m_err});
  endtask

  task automatic cyc(input bit rn, input bit en, input bit ld, input int dv, input int ms);
    @(negedge clk_in);
    reset_n = rn; enable = en; div_load = ld; div_value = W'(dv); mode_sel = 2'(ms);
    model_step();
    if (!rn) begin
      #1;
      check("async_reset", int'({clk_out, tick, div_pending, div_err}), 0);
    end
  endtask

  initial begin
    logic [3:0] e;
    forever begin
      @(posedge clk_in);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("scoreboard{clk_out,tick,pending,err}",
              int'({clk_out, tick, div_pending, div_err}), int'(e));
      end
    end
  end

  initial begin
    #1;
    check("reset_at_start", int'({clk_out, tick, div_pending, div_err}), 0);
    repeat (3) cyc(0, 0, 0, 0, 0);
    repeat (120) cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 1, 3, 0);
    repeat (150) cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 1, 4, 1);
    repeat (30) cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 2);
    repeat (5) cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 1, 7, 0);
    repeat (4) cyc(1, 0, 0, 0, 0);
    repeat (40) cyc(1, 1, 0, 0, 0);
    for (int i = 0; i < 20 && !m_out; i++) cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 1, 5, 0);
    repeat (2) cyc(0, 1, 0, 0, 0);
    repeat (210) cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 1, 6, 3);
    repeat (20) cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 1, 3, 2);
    repeat (20) cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 1, 1, 1);
    repeat (10) cyc(1, 1, 0, 0, 0);
    repeat (3000) begin
      int r;
      r = $urandom_range(0, 999);
      cyc(r >= 2, $urandom_range(0, 9) != 0, $urandom_range(0, 11) == 0,
          $urandom_range(0, 12), $urandom_range(0, 3));
    end
    repeat (2) @(posedge clk_in);
    #2;
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/clk_divider_prog.md
CLK_DIVIDER_PROG -- requirements
Module: clk_divider_prog

Interface
REQ-001 Parameter CNT_WIDTH, default 16, width of divisor and internal counter; legal range 2..32.
REQ-002 Parameter DEFAULT_DIV, default 50, divisor and shadow value loaded at reset; SHALL satisfy 1 <= DEFAULT_DIV <= 2^CNT_WIDTH-1.
REQ-003 clk_in  input  1  system clock; all logic on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 enable  input  1  1 = divider runs; 0 = counter and clk_out hold.
REQ-006 div_value  input  CNT_WIDTH  requested divisor N, sampled only when div_load=1.
REQ-007 mode_sel  input  2  requested mode, sampled only when div_load=1: 00 toggle, 01 pulse, 10 hold-low, 11 treated as 00.
REQ-008 div_load  input  1  one-cycle request to capture div_value/mode_sel into the shadow register.
REQ-009 clk_out  output  1  registered divided output.
REQ-010 tick  output  1  registered one-cycle pulse marking each clk_out rising edge.
REQ-011 div_pending  output  1  1 while a captured shadow configuration awaits application.
REQ-012 div_err  output  1  one-cycle pulse when a load is rejected.

Function
REQ-013 Active state: counter (CNT_WIDTH), div_active, mode_active; shadow state: div_shadow, mode_shadow, div_pending.
REQ-014 Terminal cycle: enable=1 and counter >= div_active-1; on terminal counter SHALL go to 0, otherwise counter SHALL increment by 1 when enable=1.
REQ-015 Toggle mode: clk_out SHALL invert on each terminal cycle; output period = 2*N clk_in cycles, 50% duty.
REQ-016 Pulse mode: clk_out SHALL equal 1 for exactly the cycle following each terminal cycle, else 0; period N; N=1 gives clk_out constant 1 while enabled.
REQ-017 Hold-low mode: counter SHALL run as in REQ-014; clk_out and tick SHALL remain 0.
REQ-018 tick SHALL be 1 in exactly those cycles where clk_out transitioned 0->1 on the preceding edge; 0 otherwise.
REQ-019 enable=0: counter and clk_out SHALL hold their values; tick SHALL be 0.
REQ-020 div_load=1 with div_value != 0: div_shadow/mode_shadow SHALL capture inputs, div_pending SHALL be 1 next cycle.
REQ-021 div_load=1 with div_value = 0: shadow and div_pending SHALL be unchanged; div_err SHALL be 1 for exactly the next cycle.
REQ-022 Load while pending: new values SHALL overwrite shadow (last wins); div_pending stays 1.
REQ-023 Apply, enable=1: on a terminal cycle with div_pending=1, div_active/mode_active SHALL take shadow values and div_pending SHALL clear; output transition of that terminal cycle SHALL follow the old mode; counter goes to 0.
REQ-024 Apply on mode change: if mode_shadow differs from mode_active, clk_out SHALL be forced to 0 on the apply edge and tick SHALL be 0.
REQ-025 Apply, enable=0: with div_pending=1, configuration SHALL apply on the next edge, counter SHALL go to 0, clk_out SHALL go to 0.
REQ-026 Simultaneous div_load and apply cycle: the pre-existing shadow SHALL be applied; new values SHALL be captured into shadow and div_pending SHALL remain 1.
REQ-027 Divisor changes SHALL never produce a clk_out high or low phase shorter than min(old N, new N) cycles in toggle mode.

Reset
REQ-028 reset_n=0 SHALL immediately force counter=0, clk_out=0, tick=0, div_err=0, div_pending=0, div_active=div_shadow=DEFAULT_DIV, mode_active=mode_shadow=00.
REQ-029 Reset mid-operation SHALL discard any pending configuration; after release, operation SHALL resume per REQ-015 with DEFAULT_DIV.
REQ-030 reset_n deassertion SHALL be synchronised externally; no output SHALL change on the release edge itself.

Verification
REQ-031 Reset release, enable=1, defaults -> clk_out first rises after 50 cycles, period 100 cycles, tick one cycle per rising edge.
REQ-032 Load N=3 mode 00 mid-period at N=50 -> div_pending=1 until next terminal, then period 6 cycles, no high/low phase <3 cycles.
REQ-033 Load N=4 mode 01 -> after apply clk_out forced 0, then one-cycle pulse every 4 cycles, tick == clk_out.
REQ-034 Load div_value=0 -> div_err pulses once, div_pending stays 0, output unchanged.
REQ-035 enable=0 with pending N=7 -> next edge counter=0, clk_out=0, div_pending=0; re-enable -> first rise after 7 cycles.
REQ-036 Assert reset_n=0 with div_pending=1, mid high phase -> all outputs 0 at once; after release period 100, no pending.
